mult_rr_sched: RTL and testbench
================================

// Module: mult_rr_sched
// PURPOSE
//  Round-robin scheduler sharing one pipelined WxW multiplier between two requesters.
//  Accepts operand pairs via valid/ready, issues at most one op per cycle to the multiplier,
//  tracks in-flight ops in a LAT-deep tag pipeline and routes each product back to its owner.
//  Sits between two client blocks and an external pipelined multiplier (fixed latency, no stall).
// PARAMETERS
//  W    4  operand width; product width is 2*W
//  LAT  4  clk edges from issue edge to product valid at mult_p (LAT >= 1)
// PORTS
//  clk         in   1    clock, posedge
//  rst         in   1    asynchronous, active-high reset
//  en          in   1    1 = grants allowed; 0 = no new grants, in-flight ops drain
//  req0_valid  in   1    requester 0 has an operand pair
//  req0_a      in   W    requester 0 multiplicand
//  req0_b      in   W    requester 0 multiplier
//  req0_ready  out  1    grant to requester 0 this cycle (combinational)
//  req1_valid / req1_a / req1_b / req1_ready   same for requester 1
//  mult_a      out  W    registered multiplicand to multiplier
//  mult_b      out  W    registered multiplier operand to multiplier
//  mult_p      in   2W   product from multiplier
//  res_valid   out  2    one-hot owner of res_p this cycle; 2'b00 = no result
//  res_p       out  2W   product (passthrough of mult_p)
//  busy        out  1    1 while any op is in flight
// BEHAVIOUR
//  - Reset (async, any time): mult_a=mult_b=0, tag pipe cleared (all slots invalid), res_valid=0,
//    busy=0, rr pointer = 1 (requester 0 wins first tie). Ops in flight at reset are dropped, never returned.
//  - Handshake: transfer when reqN_valid & reqN_ready; operands must be stable while valid & !ready.
//    ready never depends on anything but en, both valids, rr pointer. No skid buffer.
//  - Arbitration (per cycle, en=1): only one valid -> grant it; both valid -> grant requester != rr pointer;
//    rr pointer <= granted index on each transfer, unchanged otherwise. en=0 -> both ready=0.
//  - Issue: on transfer edge t, mult_a/mult_b <= granted operands, tag slot 0 <= {valid=1, owner}.
//    No transfer -> slot 0 valid=0; mult_a/mult_b hold last value.
//  - Tag pipe: LAT-entry shift register advancing every edge. After edge t+LAT, slot LAT-1 holds the op;
//    res_valid = valid ? (1<<owner) : 0, res_p = mult_p, both for exactly one cycle. No backpressure:
//    clients must accept results. Throughput 1 op/cycle; result order = issue order.
//  - busy = OR of all tag-slot valids.
//  - en falling mid-burst: already-issued ops complete normally; en rising resumes with pointer as left.
//  - Arithmetic: product computed by the multiplier; unsigned, full 2W bits, no truncation.
// CONFIGURATION
//  MULT_RR_SCHED_STATS_EN defined: adds outputs gnt_cnt0, gnt_cnt1 (8 bits each), counting transfers per
//   requester, saturating at 8'hFF, cleared by rst.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING (W=4, LAT=4, paired with the team's 4x4 pipelined multiplier)
//  1. rst=1 mid-run with 3 ops in flight -> immediately res_valid=0, busy=0; no result emerges after release.
//  2. Only req0 valid, (9,12) -> req0_ready=1 same cycle; 4 edges later res_valid=01, res_p=108, busy=0 after.
//  3. Both valid continuously, req0 (1,1), req1 (8,15) -> grants alternate 0,1,0,1; results 1,120,1,120
//     with res_valid 01,10,01,10 on consecutive cycles.
//  4. Back-to-back req1 (15,15),(0,7),(3,5) -> results 225,0,15 on 3 consecutive cycles, res_valid=10.
//  5. en=0 while both valid -> both ready=0 for all cycles; in-flight ops still return; en=1 resumes RR.
//  6. STATS_EN: 300 transfers to req0 -> gnt_cnt0=255 (saturated), gnt_cnt1=0; rst clears both.

Source files
------------

// File: rtl/mult_rr_sched.sv
// rtl/mult_rr_sched.sv - round-robin scheduler sharing one pipelined multiplier between two requesters
//
// Purpose:
//   Two clients hand operand pairs over a valid/ready handshake. At most one
//   pair per cycle is granted, registered onto mult_a/mult_b, and its owner is
//   tracked alongside it through a tag pipeline that mirrors the external
//   fixed-latency multiplier. When the tag reaches the end of the pipe, the
//   product on mult_p is routed back to its owner via a one-hot res_valid.
//
// Parameters:
//   W    operand width (product is 2*W bits)
//   LAT  clock edges from the issue edge to the product appearing on mult_p (>= 1)
//
// Ports:
//   clk, rst                   clock (posedge), asynchronous active-high reset
//   en                         1 = grants allowed; 0 = no new grants, in-flight ops drain
//   req0_valid/_a/_b/_ready    requester 0 handshake and operands (ready is combinational)
//   req1_valid/_a/_b/_ready    requester 1 handshake and operands (ready is combinational)
//   mult_a, mult_b             registered operands to the multiplier
//   mult_p                     product from the multiplier
//   res_valid                  one-hot owner of res_p this cycle, 2'b00 = no result
//   res_p                      product, passthrough of mult_p
//   busy                       1 while any op is in flight
//   gnt_cnt0, gnt_cnt1         saturating per-requester transfer counters
//                              (present only when MULT_RR_SCHED_STATS_EN is defined)
//
// Configuration macro: MULT_RR_SCHED_STATS_EN

module mult_rr_sched #(
  parameter int W   = 4,
  parameter int LAT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           req0_valid,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           req1_ready,
  output logic [W-1:0]   mult_a,
  output logic [W-1:0]   mult_b,
  input  logic [2*W-1:0] mult_p,
  output logic [1:0]     res_valid,
  output logic [2*W-1:0] res_p,
`ifdef MULT_RR_SCHED_STATS_EN
  output logic [7:0]     gnt_cnt0,
  output logic [7:0]     gnt_cnt1,
`endif
  output logic           busy
);

  // Round-robin pointer holds the index of the last granted requester.
  // Reset value 1 lets requester 0 win the first tie.
  logic           rr_q, rr_d;

  // Issue stage: operands driven to the multiplier plus the tag of the op
  // issued on the same edge.
  logic [W-1:0]   mult_a_q, mult_a_d;
  logic [W-1:0]   mult_b_q, mult_b_d;
  logic           iss_vld_q, iss_vld_d;
  logic           iss_own_q, iss_own_d;

  // Tag shift pipe. An op issued on edge t sits in iss_* after edge t and in
  // entry k after edge t+1+k, so the last entry lines up with mult_p exactly
  // LAT edges after issue.
  logic [LAT-1:0] tag_vld_q, tag_vld_d;
  logic [LAT-1:0] tag_own_q, tag_own_d;

  logic           gnt0, gnt1, xfer;

  // ------------------------------------------------------------------
  // Arbitration: depends only on en, both valids and the rr pointer.
  // On a tie the requester that was not granted last wins.
  // ------------------------------------------------------------------
  always_comb begin
    gnt0 = en & req0_valid & (~req1_valid | rr_q);
    gnt1 = en & req1_valid & (~req0_valid | ~rr_q);
    xfer = gnt0 | gnt1;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // ------------------------------------------------------------------
  // Next-state for pointer, issue stage and tag pipe
  // ------------------------------------------------------------------
  always_comb begin
    rr_d      = rr_q;
    mult_a_d  = mult_a_q;
    mult_b_d  = mult_b_q;
    iss_vld_d = 1'b0;
    iss_own_d = 1'b0;
    tag_vld_d = '0;
    tag_own_d = '0;

    if (xfer) begin
      rr_d      = gnt1;
      iss_vld_d = 1'b1;
      iss_own_d = gnt1;
      mult_a_d  = gnt1 ? req1_a : req0_a;
      mult_b_d  = gnt1 ? req1_b : req0_b;
    end

    // Loop form keeps LAT=1 legal (no negative slice bounds).
    tag_vld_d[0] = iss_vld_q;
    tag_own_d[0] = iss_own_q;
    for (int i = 1; i < LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q      <= 1'b1;
      mult_a_q  <= '0;
      mult_b_q  <= '0;
      iss_vld_q <= 1'b0;
      iss_own_q <= 1'b0;
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      rr_q      <= rr_d;
      mult_a_q  <= mult_a_d;
      mult_b_q  <= mult_b_d;
      iss_vld_q <= iss_vld_d;
      iss_own_q <= iss_own_d;
      tag_vld_q <= tag_vld_d;
      tag_own_q <= tag_own_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs. Results carry no backpressure; res_valid is decoded straight
  // from the tail of the tag pipe so an async reset squashes it at once.
  // ------------------------------------------------------------------
  assign mult_a = mult_a_q;
  assign mult_b = mult_b_q;
  assign res_p  = mult_p;

  always_comb begin
    res_valid = 2'b00;
    if (tag_vld_q[LAT-1]) begin
      res_valid = tag_own_q[LAT-1] ? 2'b10 : 2'b01;
    end
  end

  assign busy = iss_vld_q | (|tag_vld_q);

`ifdef MULT_RR_SCHED_STATS_EN
  // ------------------------------------------------------------------
  // Per-requester transfer counters, saturating at 8'hFF
  // ------------------------------------------------------------------
  logic [7:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [7:0] gnt_cnt1_q, gnt_cnt1_d;

  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    if (gnt0 && (gnt_cnt0_q != 8'hFF)) gnt_cnt0_d = gnt_cnt0_q + 8'd1;
    if (gnt1 && (gnt_cnt1_q != 8'hFF)) gnt_cnt1_d = gnt_cnt1_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0_q <= 8'd0;
      gnt_cnt1_q <= 8'd0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_mult_rr_sched.sv
// tb/tb_mult_rr_sched.sv - directed self-checking bench for mult_rr_sched with a 4-stage multiplier model

module tb_mult_rr_sched;

  localparam int W   = 4;
  localparam int LAT = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           req0_valid, req1_valid;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic           req0_ready, req1_ready;
  logic [W-1:0]   mult_a, mult_b;
  logic [2*W-1:0] mult_p;
  logic [1:0]     res_valid;
  logic [2*W-1:0] res_p;
  logic           busy;
`ifdef MULT_RR_SCHED_STATS_EN
  logic [7:0]     gnt_cnt0, gnt_cnt1;
`endif

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_rr_sched #(.W(W), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_p     (mult_p),
    .res_valid  (res_valid),
    .res_p      (res_p),
`ifdef MULT_RR_SCHED_STATS_EN
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1),
`endif
    .busy       (busy)
  );

  // External pipelined multiplier: LAT register stages, no stall.
  logic [2*W-1:0] mstage [LAT];
  initial for (int i = 0; i < LAT; i++) mstage[i] = '0;
  always @(posedge clk) begin
    mstage[0] <= mult_a * mult_b;
    for (int i = 1; i < LAT; i++) mstage[i] <= mstage[i-1];
  end
  assign mult_p = mstage[LAT-1];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_mult_a", mult_a, 0);
    chk("rst_mult_b", mult_b, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    en = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_tie_ready0", req0_ready, 1);
    chk("rst_tie_ready1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    rst = 1'b0;

    // Test 1: reset with three ops in flight
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2;
    tick();
    req0_a = 4'd3; req0_b = 4'd4;
    tick();
    req0_a = 4'd5; req0_b = 4'd6;
    tick();
    req0_valid = 1'b0;
    chk("t1_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("t1_res_valid_in_rst", res_valid, 0);
    chk("t1_busy_in_rst", busy, 0);
    chk("t1_mult_a_in_rst", mult_a, 0);
    tick();
    rst = 1'b0;
    repeat (6) begin
      tick();
      chk("t1_no_result", res_valid, 0);
    end

    // Test 2: single op from req0
    req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd12;
    #1;
    chk("t2_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    chk("t2_mult_a", mult_a, 9);
    chk("t2_mult_b", mult_b, 12);
    chk("t2_busy", busy, 1);
    repeat (3) begin
      tick();
      chk("t2_res_early", res_valid, 0);
    end
    tick();
    chk("t2_res_valid", res_valid, 2'b01);
    chk("t2_res_p", res_p, 108);
    tick();
    chk("t2_res_after", res_valid, 0);
    chk("t2_busy_after", busy, 0);

    // Test 3: both valid continuously, pointer freshly reset
    rst = 1'b1;
    #1;
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1;
    req1_valid = 1'b1; req1_a = 4'd8; req1_b = 4'd15;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_ready0", req0_ready, (k % 2 == 0) ? 1 : 0);
      chk("t3_ready1", req1_ready, (k % 2 == 1) ? 1 : 0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_res_valid", res_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("t3_res_p", res_p, (k % 2 == 0) ? 1 : 120);
    end
    tick();
    chk("t3_res_end", res_valid, 0);

    // Test 4: back-to-back req1
    req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd15;
    #1;
    chk("t4_ready1_a", req1_ready, 1);
    tick();
    req1_a = 4'd0; req1_b = 4'd7;
    #1;
    chk("t4_ready1_b", req1_ready, 1);
    tick();
    req1_a = 4'd3; req1_b = 4'd5;
    #1;
    chk("t4_ready1_c", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("t4_res_early", res_valid, 0);
    tick();
    chk("t4_res_valid0", res_valid, 2'b10);
    chk("t4_res_p0", res_p, 225);
    tick();
    chk("t4_res_valid1", res_valid, 2'b10);
    chk("t4_res_p1", res_p, 0);
    tick();
    chk("t4_res_valid2", res_valid, 2'b10);
    chk("t4_res_p2", res_p, 15);
    tick();
    chk("t4_res_end", res_valid, 0);

    // Test 5: en low while both valid; in-flight op drains; en high resumes RR
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3;
    #1;
    chk("t5_ready0_issue", req0_ready, 1);
    tick();
    en = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd4; req1_b = 4'd5;
    for (int i = 1; i <= 6; i++) begin
      #1;
      chk("t5_ready0_off", req0_ready, 0);
      chk("t5_ready1_off", req1_ready, 0);
      if (i == 5) begin
        chk("t5_drain_valid", res_valid, 2'b01);
        chk("t5_drain_p", res_p, 6);
      end else begin
        chk("t5_drain_idle", res_valid, 0);
      end
      tick();
    end
    chk("t5_busy_idle", busy, 0);
    en = 1'b1;
    #1;
    chk("t5_resume_ready1", req1_ready, 1);
    chk("t5_resume_ready0", req0_ready, 0);
    tick();
    #1;
    chk("t5_next_ready0", req0_ready, 1);
    chk("t5_next_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("t5_wait_a", res_valid, 0);
    tick();
    chk("t5_wait_b", res_valid, 0);
    tick();
    chk("t5_res_valid1", res_valid, 2'b10);
    chk("t5_res_p1", res_p, 20);
    tick();
    chk("t5_res_valid0", res_valid, 2'b01);
    chk("t5_res_p0", res_p, 6);
    tick();
    chk("t5_busy_end", busy, 0);

`ifdef MULT_RR_SCHED_STATS_EN
    // Test 6: saturating grant counters
    rst = 1'b1;
    #1;
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1;
    repeat (300) @(posedge clk);
    #1;
    req0_valid = 1'b0;
    chk("t6_cnt0_sat", gnt_cnt0, 255);
    chk("t6_cnt1_zero", gnt_cnt1, 0);
    rst = 1'b1;
    #1;
    chk("t6_cnt0_rst", gnt_cnt0, 0);
    chk("t6_cnt1_rst", gnt_cnt1, 0);
    rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
